// File: rtl/button_bank.sv
// Debounced key bank: per-key 2-flop synchroniser and debounce FSM, with a
// small read-only register window (pending, level, press count) and an irq.
module button_bank #(
  parameter int CLKRATE  = 25000000,
  parameter int DBMSEC   = 150,
  parameter int NKEYS    = 4,
  parameter int BASEADDR = 411700
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NKEYS-1:0] key,
  input  logic [31:0]      busaddr,
  input  logic             busrd,
  output logic [31:0]      busdata,
  output logic             irq
);

  localparam int DBMAX = CLKRATE / 1000 * DBMSEC;
  localparam int CW    = $clog2(DBMAX) + 1;
  // Transition fires on the cycle the count would reach DBMAX.
  localparam logic [CW-1:0] CLAST = CW'(DBMAX - 1);

  localparam logic [31:0] ADDR_PEND  = 32'(BASEADDR);
  localparam logic [31:0] ADDR_LEVEL = 32'(BASEADDR + 4);
  localparam logic [31:0] ADDR_CNT   = 32'(BASEADDR + 8);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NKEYS-1:0] sync1, sync2;
  logic [NKEYS-1:0] press, level;
  logic [NKEYS-1:0] pending;
  logic [15:0]      presscnt;
  logic [4:0]       npress;
  logic [15:0]      cnt_base;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_next;
  logic             rd_pend, rd_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    state_t        st, st_nx;
    logic [CW-1:0] dc, dc_nx;
    logic          hit;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        st <= RELEASED;
        dc <= '0;
      end else begin
        st <= st_nx;
        dc <= dc_nx;
      end
    end

    always_comb begin
      st_nx = st;
      dc_nx = dc;
      hit   = 1'b0;
      case (st)
        RELEASED: begin
          if (!sync2[g]) begin
            st_nx = PRESS_WAIT;
            dc_nx = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (sync2[g]) begin
            st_nx = RELEASED;
            dc_nx = '0;
          end else if (dc == CLAST) begin
            st_nx = PRESSED;
            dc_nx = '0;
            hit   = 1'b1;
          end else begin
            dc_nx = dc + CW'(1);
          end
        end
        PRESSED: begin
          if (sync2[g]) begin
            st_nx = RELEASE_WAIT;
            dc_nx = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!sync2[g]) begin
            st_nx = PRESSED;
            dc_nx = '0;
          end else if (dc == CLAST) begin
            st_nx = RELEASED;
            dc_nx = '0;
          end else begin
            dc_nx = dc + CW'(1);
          end
        end
        default: begin
          st_nx = RELEASED;
          dc_nx = '0;
        end
      endcase
    end

    assign press[g] = hit;
    assign level[g] = (st == PRESSED) || (st == RELEASE_WAIT);
  end

  assign rd_pend = busrd && (busaddr == ADDR_PEND);
  assign rd_cnt  = busrd && (busaddr == ADDR_CNT);

  // Clear is applied before new events are merged, so a coincident set wins.
  always_comb begin
    npress = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      npress = npress + 5'(press[i]);
    end
    cnt_base = rd_cnt ? '0 : presscnt;
    cnt_sum  = {1'b0, cnt_base} + 17'(npress);
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending  <= '0;
      presscnt <= '0;
      irq      <= 1'b0;
    end else begin
      pending  <= (rd_pend ? '0 : pending) | press;
      presscnt <= cnt_next;
      irq      <= |pending;
    end
  end

  always_comb begin
    busdata = '0;
    if (busaddr == ADDR_PEND) begin
      busdata[NKEYS-1:0] = pending;
    end else if (busaddr == ADDR_LEVEL) begin
      busdata[NKEYS-1:0] = level;
    end else if (busaddr == ADDR_CNT) begin
      busdata[15:0] = presscnt;
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: directed scenarios plus random key and
// bus traffic compared against a run-length debounce model.
module tb_button_bank;

  localparam int NK    = 4;
  localparam int BASE  = 411700;
  localparam int DBMAX = 10;
  localparam logic [31:0] A0 = 32'(BASE);
  localparam logic [31:0] A4 = 32'(BASE + 4);
  localparam logic [31:0] A8 = 32'(BASE + 8);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NK-1:0] key = '1;
  logic [31:0]   busaddr = '0;
  logic          busrd = 1'b0;
  logic [31:0]   busdata;
  logic          irq;

  logic [15:0]   key2 = '1;
  logic [31:0]   busaddr2 = A8;
  logic          busrd2 = 1'b0;
  logic [31:0]   busdata2;
  logic          irq2;

  button_bank #(.CLKRATE(10000), .DBMSEC(1), .NKEYS(NK), .BASEADDR(BASE)) dut (
    .clk(clk), .nrst(nrst), .key(key), .busaddr(busaddr), .busrd(busrd),
    .busdata(busdata), .irq(irq)
  );

  // Short debounce window and 16 keys so the press counter can be driven to saturation quickly.
  button_bank #(.CLKRATE(2000), .DBMSEC(1), .NKEYS(16), .BASEADDR(BASE)) sat (
    .clk(clk), .nrst(nrst), .key(key2), .busaddr(busaddr2), .busrd(busrd2),
    .busdata(busdata2), .irq(irq2)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a key's debounced level flips after DBMAX consecutive
  // synchronised samples that disagree with it.
  logic [NK-1:0] m_s1, m_s2, m_deb, m_pend;
  int            m_run [NK];
  int            m_cnt;
  logic          m_irq;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_deb = '0; m_pend = '0;
    m_cnt = 0; m_irq = 1'b0;
    foreach (m_run[i]) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [NK-1:0] set;
    int n;
    set = '0;
    n = 0;
    if (!nrst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NK; i++) begin
      if (!m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DBMAX) begin
          m_deb[i] = !m_s2[i];
          m_run[i] = 0;
          if (m_deb[i]) begin
            set[i] = 1'b1;
            n++;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = key;
    m_irq = |m_pend;
    if (busrd && busaddr == A0) m_pend = '0;
    m_pend = m_pend | set;
    if (busrd && busaddr == A8) m_cnt = 0;
    m_cnt = m_cnt + n;
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a == A0) return 32'(m_pend);
    if (a == A4) return 32'(m_deb);
    if (a == A8) return 32'(m_cnt);
    return 32'h0;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic [NK-1:0] k, input logic rd, input logic [31:0] a);
    key = k;
    busrd = rd;
    busaddr = a;
    #1;
    check({phase, ":busdata"}, busdata, exp_read(a));
    check({phase, ":irq"}, 32'(irq), 32'(m_irq));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    busrd = 1'b0;
    busaddr = a;
    #1;
    check(tag, busdata, exp);
  endtask

  int s_cnt = 0;

  task automatic sat_round(input logic [15:0] m);
    key2 = ~m;
    repeat (5) @(negedge clk);
    key2 = '1;
    repeat (5) @(negedge clk);
    s_cnt = s_cnt + $countones(m);
    if (s_cnt > 65535) s_cnt = 65535;
  endtask

  logic [NK-1:0] lvl;
  int            hold [NK];
  logic [31:0]   ra;

  initial begin
    model_reset();
    @(negedge clk);
    phase = "reset";
    peek("rst_pend", A0, 0);
    peek("rst_level", A4, 0);
    peek("rst_cnt", A8, 0);
    check("rst_irq", 32'(irq), 0);
    nrst = 1'b1;

    phase = "clean";
    repeat (11) cyc(4'b1110, 1'b0, A0);
    peek("lat11", A0, 0);
    cyc(4'b1110, 1'b0, A0);
    peek("lat12", A0, 1);
    check("irq12", 32'(irq), 0);
    cyc(4'b1110, 1'b0, A0);
    check("irq13", 32'(irq), 1);
    repeat (7) cyc(4'b1110, 1'b0, A4);
    peek("level_on", A4, 1);
    repeat (11) cyc(4'b1111, 1'b0, A4);
    peek("level_11", A4, 1);
    cyc(4'b1111, 1'b0, A4);
    peek("level_off", A4, 0);
    peek("cnt_one", A8, 1);
    cyc(4'b1111, 1'b1, A8);
    cyc(4'b1111, 1'b1, A0);
    peek("cnt_cleared", A8, 0);

    phase = "bounce";
    repeat (9) cyc(4'b1101, 1'b0, A0);
    cyc(4'b1111, 1'b0, A0);
    repeat (9) cyc(4'b1101, 1'b0, A0);
    repeat (15) cyc(4'b1111, 1'b0, A0);
    peek("bounce_pend", A0, 0);
    peek("bounce_cnt", A8, 0);

    phase = "race";
    repeat (12) cyc(4'b1110, 1'b0, A0);
    peek("race_pre", A0, 1);
    repeat (11) cyc(4'b1011, 1'b0, A0);
    busrd = 1'b1;
    #1;
    check("race_rd", busdata, 1);
    @(posedge clk);
    model_step();
    @(negedge clk);
    peek("race_post", A0, 4);
    check("race_irq", 32'(irq), 1);
    cyc(4'b1011, 1'b0, A0);
    check("race_irq2", 32'(irq), 1);
    repeat (13) cyc(4'b1111, 1'b0, A4);
    cyc(4'b1111, 1'b1, A0);
    cyc(4'b1111, 1'b1, A8);

    phase = "simul";
    repeat (12) cyc(4'b0000, 1'b0, A0);
    peek("sim_pend", A0, 32'hF);
    peek("sim_cnt", A8, 4);
    cyc(4'b0000, 1'b1, A8);
    peek("sim_cnt_clr", A8, 0);
    repeat (13) cyc(4'b1111, 1'b0, A4);
    cyc(4'b1111, 1'b1, A0);

    phase = "rstmid";
    repeat (7) cyc(4'b1110, 1'b0, A0);
    nrst = 1'b0;
    model_reset();
    peek("rm_pend", A0, 0);
    peek("rm_level", A4, 0);
    peek("rm_cnt", A8, 0);
    check("rm_irq", 32'(irq), 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    nrst = 1'b1;
    repeat (11) cyc(4'b1110, 1'b0, A0);
    peek("rm_lat11", A0, 0);
    cyc(4'b1110, 1'b0, A0);
    peek("rm_lat12", A0, 1);
    repeat (13) cyc(4'b1111, 1'b0, A0);

    phase = "random";
    foreach (hold[i]) hold[i] = 0;
    lvl = '1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 24));
        end
        hold[i]--;
      end
      case ($urandom_range(0, 4))
        0: ra = A0;
        1: ra = A4;
        2: ra = A8;
        3: ra = A8 + 32'd4;
        default: ra = $urandom;
      endcase
      if ($urandom_range(0, 799) == 0) begin
        nrst = 1'b0;
        model_reset();
      end else begin
        nrst = 1'b1;
      end
      cyc(lvl, 1'($urandom_range(0, 3) == 0), ra);
    end
    nrst = 1'b1;
    repeat (14) cyc(4'b1111, 1'b0, A0);

    phase = "sat";
    busaddr2 = A8;
    busrd2 = 1'b0;
    cyc(4'b1111, 1'b0, A0);
    #1;
    check("sat_start", busdata2, 0);
    for (int r = 0; r < 4095; r++) sat_round(16'hFFFF);
    sat_round(16'h3FFF);
    #1;
    check("sat_fffe", busdata2, 32'hFFFE);
    sat_round(16'h0001);
    #1;
    check("sat_ffff", busdata2, 32'hFFFF);
    sat_round(16'h0002);
    #1;
    check("sat_hold", busdata2, 32'(s_cnt));
    sat_round(16'hFFFF);
    #1;
    check("sat_hold16", busdata2, 32'hFFFF);
    check("sat_irq", 32'(irq2), 1);
    busrd2 = 1'b1;
    #1;
    check("sat_rd", busdata2, 32'hFFFF);
    @(negedge clk);
    busrd2 = 1'b0;
    #1;
    check("sat_clr", busdata2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
